// File: rtl/encoder_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : encoder_mux_arbiter_if
// Brief    : Request/code bus between the front-panel encoders and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface encoder_mux_arbiter_if #(
  parameter int CODE_W = 4
);
  logic              req_a;
  logic [CODE_W-1:0] code_a;
  logic              req_b;
  logic [CODE_W-1:0] code_b;
  logic              seletor;
  logic              ack_a;
  logic              ack_b;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              busy;

  modport master (
    output req_a, code_a, req_b, code_b,
    input  seletor, ack_a, ack_b, code_out, code_valid, busy
  );

  modport slave (
    input  req_a, code_a, req_b, code_b,
    output seletor, ack_a, ack_b, code_out, code_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/encoder_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : encoder_mux_arbiter
// Brief    : Round-robin arbiter sharing the 2:1 encoder mux; one registered
//            code per accepted press, grant held for a settle window.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_mux_arbiter #(
  parameter int CODE_W      = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_mux_arbiter_if.slave bus
);

  localparam int c_CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_INIT =
    (HOLD_CYCLES > 0) ? c_CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GRANT   = 2'd1;
  localparam logic [1:0] c_HOLD    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_last_a;   // 1 = last grant went to A
  logic               r_sel;
  logic               r_ack_a;
  logic               r_ack_b;
  logic [CODE_W-1:0]  r_code;
  logic               r_valid;
  logic               r_busy;

  logic [1:0]         w_next_state;
  logic [c_CNT_W-1:0] w_next_cnt;
  logic               w_grant;
  logic               w_win_a;
  logic               w_gnt_req;

  assign w_grant   = (r_state == c_IDLE) && (bus.req_a || bus.req_b);
  // On a tie the source that did not win last time gets the grant.
  assign w_win_a   = bus.req_a && (!bus.req_b || !r_last_a);
  assign w_gnt_req = r_last_a ? bus.req_a : bus.req_b;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_grant) w_next_state = c_GRANT;
      end
      c_GRANT: begin
        if (HOLD_CYCLES == 0) begin
          w_next_state = c_RELEASE;
        end else begin
          w_next_state = c_HOLD;
          w_next_cnt   = c_HOLD_INIT;
        end
      end
      c_HOLD: begin
        if (r_cnt == '0) w_next_state = c_RELEASE;
        else             w_next_cnt   = r_cnt - c_CNT_ONE;
      end
      c_RELEASE: begin
        if (!w_gnt_req) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_last_a <= 1'b0;
      r_sel    <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_busy  <= (w_next_state != c_IDLE);
      r_ack_a <= w_grant && w_win_a;
      r_ack_b <= w_grant && !w_win_a;
      r_valid <= w_grant;
      if (w_grant) begin
        r_sel    <= w_win_a;
        r_last_a <= w_win_a;
        r_code   <= w_win_a ? bus.code_a : bus.code_b;
      end
    end
  end

  assign bus.seletor    = r_sel;
  assign bus.ack_a      = r_ack_a;
  assign bus.ack_b      = r_ack_b;
  assign bus.code_out   = r_code;
  assign bus.code_valid = r_valid;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_encoder_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_mux_arbiter
// Brief    : Directed self-checking bench for encoder_mux_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_mux_arbiter;

  localparam int CODE_W      = 4;
  localparam int HOLD_CYCLES = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   n_ack;
  int   n_valid;
  int   n_busy_low;

  encoder_mux_arbiter_if #(.CODE_W(CODE_W)) bus ();

  encoder_mux_arbiter #(
    .CODE_W      (CODE_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b0) break;
      step();
    end
    chk(tag, bus.busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.code_a = '0;
    bus.code_b = '0;

    // 1: asynchronous reset mid-cycle
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_seletor", bus.seletor, 1);
    chk("rst_code_out", bus.code_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.code_valid, 0);
    chk("rst_acks", {bus.ack_a, bus.ack_b}, 0);
    step();
    rst_n = 1'b1;

    // 2: single A request
    bus.req_a = 1'b1;
    bus.code_a = 4'h7;
    step();
    chk("a_ack", bus.ack_a, 1);
    chk("a_valid", bus.code_valid, 1);
    chk("a_code", bus.code_out, 4'h7);
    chk("a_sel", bus.seletor, 1);
    chk("a_ackb", bus.ack_b, 0);
    step();
    chk("a_pulse_end", {bus.ack_a, bus.code_valid}, 0);
    chk("a_busy_e1", bus.busy, 1);
    for (int e = 2; e <= 8; e++) step();
    chk("a_busy_e8", bus.busy, 1);
    bus.req_a = 1'b0;
    step();
    chk("a_idle_e9", bus.busy, 0);
    chk("a_code_hold", bus.code_out, 4'h7);

    // 3: tie after reset goes to A; B follows one IDLE cycle after release
    pulse_reset();
    step();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.code_a = 4'h3;
    bus.code_b = 4'h9;
    step();
    chk("tie_ack_a", {bus.ack_a, bus.ack_b}, 2'b10);
    chk("tie_code_a", bus.code_out, 4'h3);
    bus.req_a = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    chk("tie_busy_e5", bus.busy, 1);
    chk("tie_nob_e5", bus.ack_b, 0);
    step();
    chk("tie_idle_e6", bus.busy, 0);
    chk("tie_nob_e6", bus.ack_b, 0);
    step();
    chk("tie_ack_b", {bus.ack_a, bus.ack_b}, 2'b01);
    chk("tie_valid_b", bus.code_valid, 1);
    chk("tie_code_b", bus.code_out, 4'h9);
    chk("tie_sel_b", bus.seletor, 0);
    bus.req_b = 1'b0;
    step();
    wait_idle("tie_b_release");
    chk("sel_kept_idle", bus.seletor, 0);

    // 4: round robin; A granted alone, then tie -> B, next tie -> A
    bus.req_a = 1'b1;
    bus.code_a = 4'h5;
    step();
    chk("rr_a_alone", {bus.ack_a, bus.code_out}, {1'b1, 4'h5});
    bus.req_a = 1'b0;
    step();
    wait_idle("rr_a_release");
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.code_a = 4'h1;
    bus.code_b = 4'h2;
    step();
    chk("rr_tie1_b", {bus.ack_a, bus.ack_b, bus.seletor}, 3'b010);
    chk("rr_tie1_code", bus.code_out, 4'h2);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();
    wait_idle("rr_tie1_release");
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.code_a = 4'hA;
    bus.code_b = 4'hB;
    step();
    chk("rr_tie2_a", {bus.ack_a, bus.ack_b, bus.seletor}, 3'b101);
    chk("rr_tie2_code", bus.code_out, 4'hA);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();
    wait_idle("rr_tie2_release");

    // 5: key held for 50 cycles yields a single accepted press
    n_ack = 0;
    n_valid = 0;
    n_busy_low = 0;
    bus.req_a = 1'b1;
    bus.code_a = 4'h6;
    for (int c = 0; c < 50; c++) begin
      step();
      if (bus.ack_a === 1'b1) n_ack++;
      if (bus.code_valid === 1'b1) n_valid++;
      if (bus.busy !== 1'b1) n_busy_low++;
    end
    chk("held_acks", n_ack, 1);
    chk("held_valids", n_valid, 1);
    chk("held_busy_low", n_busy_low, 0);
    bus.req_a = 1'b0;
    step();
    chk("held_release", bus.busy, 0);

    // 6: reset during HOLD; request still high afterwards is new
    bus.req_b = 1'b1;
    bus.code_b = 4'hC;
    step();
    chk("hr_ack_b", {bus.ack_b, bus.code_out}, {1'b1, 4'hC});
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("hr_rst_code", bus.code_out, 0);
    chk("hr_rst_busy", bus.busy, 0);
    chk("hr_rst_sel", bus.seletor, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("hr_regrant", {bus.ack_b, bus.code_valid, bus.seletor}, 3'b110);
    chk("hr_code", bus.code_out, 4'hC);
    bus.req_b = 1'b0;
    step();
    wait_idle("hr_release");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
